// File: rtl/systolic_feeder_pkg.sv
// systolic_pkg: shared FSM state type and sizing helpers for the systolic feeder
package systolic_pkg;
  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} feeder_state_e;
  function automatic int cnt_w(input int max_k);
    return $clog2(max_k + 1);
  endfunction
  function automatic int flush_len(input int rows, input int cols, input int pe_lat);
    return rows + cols - 1 + pe_lat;
  endfunction
endpackage

// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: controller-side handshake plus array-edge outputs of the feeder
// master: controller/array side (drives start, k_len, act/wgt beats; sees readies, edge outputs, busy/done)
// slave:  feeder side
interface systolic_feeder_if #(
  parameter int INPUT_WIDTH  = 32,
  parameter int WEIGHT_WIDTH = 32,
  parameter int NUM_ROWS     = 16,
  parameter int NUM_COLS     = 16,
  parameter int MAX_K        = 1024
);
  logic                                   start_i;
  logic [$clog2(MAX_K+1)-1:0]             k_len_i;
  logic [NUM_ROWS-1:0][INPUT_WIDTH-1:0]   act_data_i;
  logic                                   act_valid_i;
  logic                                   act_ready_o;
  logic [NUM_COLS-1:0][WEIGHT_WIDTH-1:0]  wgt_data_i;
  logic                                   wgt_valid_i;
  logic                                   wgt_ready_o;
  logic [NUM_ROWS-1:0][INPUT_WIDTH-1:0]   input_o;
  logic [NUM_ROWS-1:0]                    input_valid_o;
  logic [NUM_COLS-1:0][WEIGHT_WIDTH-1:0]  weight_o;
  logic [NUM_COLS-1:0]                    weight_valid_o;
  logic                                   busy_o;
  logic                                   done_o;
  modport master (
    output start_i, k_len_i, act_data_i, act_valid_i, wgt_data_i, wgt_valid_i,
    input  act_ready_o, wgt_ready_o, input_o, input_valid_o, weight_o, weight_valid_o, busy_o, done_o
  );
  modport slave (
    input  start_i, k_len_i, act_data_i, act_valid_i, wgt_data_i, wgt_valid_i,
    output act_ready_o, wgt_ready_o, input_o, input_valid_o, weight_o, weight_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/systolic_feeder_skew_line.sv
// skew_line: DEPTH-stage data/valid delay line with no enable, so skew survives stalls
// ports: clk_i, rst_i (sync, active-high), data_i/valid_i in, data_o/valid_o out
// SYSTOLIC_FEEDER_ZERO_FILL_EN: bubbles load data 0; otherwise data holds on bubbles
module skew_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);
  logic [WIDTH-1:0] d  [DEPTH];
  logic             v  [DEPTH];
  logic [WIDTH-1:0] di [DEPTH+1];
  logic             vi [DEPTH+1];
  always_comb begin
    di[0] = data_i;
    vi[0] = valid_i;
    for (int s = 0; s < DEPTH; s++) begin
      di[s+1] = d[s];
      vi[s+1] = v[s];
    end
  end
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < DEPTH; s++) begin
      if (rst_i) begin
        d[s] <= '0;
        v[s] <= 1'b0;
      end else begin
        v[s] <= vi[s];
`ifdef SYSTOLIC_FEEDER_ZERO_FILL_EN
        d[s] <= vi[s] ? di[s] : '0;
`else
        if (vi[s]) d[s] <= di[s];
`endif
      end
    end
  end
  assign data_o  = di[DEPTH];
  assign valid_o = vi[DEPTH];
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: joint act/wgt handshake, diagonal skew onto the array edges, drain count and done pulse
// ports: clk_i, rst_i (sync, active-high), bus (systolic_feeder_if.slave: start/k_len, act/wgt beats,
//        readies, skewed input/weight edges with valids, busy_o, done_o)
// SYSTOLIC_FEEDER_ZERO_FILL_EN: invalid edge slots read 0 instead of holding stale data
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int INPUT_WIDTH  = 32,
  parameter int WEIGHT_WIDTH = 32,
  parameter int NUM_ROWS     = 16,
  parameter int NUM_COLS     = 16,
  parameter int MAX_K        = 1024,
  parameter int PE_LATENCY   = 1
) (
  input logic              clk_i,
  input logic              rst_i,
  systolic_feeder_if.slave bus
);
  localparam int CW = cnt_w(MAX_K);
  localparam logic [CW-1:0] F = CW'(flush_len(NUM_ROWS, NUM_COLS, PE_LATENCY));
  feeder_state_e state;
  logic [CW-1:0] k, beat, flush;
  logic busy, done, fire;
  assign fire            = state == FEED && bus.act_valid_i && bus.wgt_valid_i;
  assign bus.act_ready_o = state == FEED && bus.wgt_valid_i;
  assign bus.wgt_ready_o = state == FEED && bus.act_valid_i;
  assign bus.busy_o      = busy;
  assign bus.done_o      = done;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      k     <= '0;
      beat  <= '0;
      flush <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start_i) begin
          busy  <= 1'b1;
          k     <= bus.k_len_i;
          beat  <= '0;
          done  <= bus.k_len_i == '0;
          state <= bus.k_len_i == '0 ? DONE : FEED;
        end
        FEED: if (fire) begin
          beat <= beat + CW'(1);
          if (beat == k - CW'(1)) begin
            flush <= F;
            state <= FLUSH;
          end
        end
        FLUSH: begin
          flush <= flush - CW'(1);
          if (flush == CW'(1)) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
  for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
    skew_line #(.WIDTH(INPUT_WIDTH), .DEPTH(i + 1)) u_line (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .data_i (bus.act_data_i[i]),
      .valid_i(fire),
      .data_o (bus.input_o[i]),
      .valid_o(bus.input_valid_o[i])
    );
  end
  for (genvar j = 0; j < NUM_COLS; j++) begin : g_col
    skew_line #(.WIDTH(WEIGHT_WIDTH), .DEPTH(j + 1)) u_line (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .data_i (bus.wgt_data_i[j]),
      .valid_i(fire),
      .data_o (bus.weight_o[j]),
      .valid_o(bus.weight_valid_o[j])
    );
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: table of passes plus reset sequences, edge outputs checked against a per-lane scoreboard
module tb_systolic_feeder;
  import systolic_pkg::*;
  localparam int R = 4;
  localparam int C = 4;
  localparam int W = 32;
  localparam int MK = 1024;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  systolic_feeder_if #(.INPUT_WIDTH(W), .WEIGHT_WIDTH(W), .NUM_ROWS(R), .NUM_COLS(C), .MAX_K(MK)) bus ();
  systolic_feeder #(.INPUT_WIDTH(W), .WEIGHT_WIDTH(W), .NUM_ROWS(R), .NUM_COLS(C), .MAX_K(MK), .PE_LATENCY(1)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );
  int tick = 0;
  always @(posedge clk) tick <= tick + 1;
  int compared = 0;
  int mismatched = 0;
  logic [63:0] rq[R][$];
  logic [63:0] wq[C][$];
  typedef struct {
    int k;
    int stall;
    int done_c;
    bit poke;
  } vec_t;
  vec_t vec[5];
  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, exp, tick);
    end
  endtask
  always @(negedge clk) begin
    logic [63:0] e;
    for (int i = 0; i < R; i++)
      if (bus.input_valid_o[i]) begin
        if (rq[i].size() == 0) chk($sformatf("row%0d unexpected valid", i), 1, 0);
        else begin
          e = rq[i].pop_front();
          chk($sformatf("row%0d data", i), longint'(bus.input_o[i]), longint'(e[31:0]));
          chk($sformatf("row%0d cycle", i), tick, longint'(e[63:32]));
        end
      end
    for (int j = 0; j < C; j++)
      if (bus.weight_valid_o[j]) begin
        if (wq[j].size() == 0) chk($sformatf("col%0d unexpected valid", j), 1, 0);
        else begin
          e = wq[j].pop_front();
          chk($sformatf("col%0d data", j), longint'(bus.weight_o[j]), longint'(e[31:0]));
          chk($sformatf("col%0d cycle", j), tick, longint'(e[63:32]));
        end
      end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, " busy"}, bus.busy_o, 0);
    chk({tag, " done"}, bus.done_o, 0);
    chk({tag, " input_valid"}, longint'(bus.input_valid_o), 0);
    chk({tag, " weight_valid"}, longint'(bus.weight_valid_o), 0);
    chk({tag, " input_o zero"}, bus.input_o == '0, 1);
    chk({tag, " weight_o zero"}, bus.weight_o == '0, 1);
  endtask
  task automatic run_pass(input int k, input int stall, input int done_c, input bit poke);
    int base;
    int b;
    bit feed;
    b = 0;
    bus.start_i = 1'b1;
    bus.k_len_i = 11'(k);
    base = tick;
    for (int c = 1; c <= done_c + 2; c++) begin
      step();
      bus.start_i = poke && c == k + 2;
      bus.k_len_i = bus.start_i ? 11'd5 : 11'(k);
      bus.act_valid_i = 1'b0;
      bus.wgt_valid_i = 1'b0;
      feed = b < k;
      if (feed) begin
        for (int i = 0; i < R; i++) bus.act_data_i[i] = 32'(b * 16 + i + 1);
        for (int j = 0; j < C; j++) bus.wgt_data_i[j] = 32'(b * 16 + j + 5);
        bus.act_valid_i = 1'b1;
        bus.wgt_valid_i = c != stall;
        if (c != stall) begin
          for (int i = 0; i < R; i++) rq[i].push_back({32'(base + c + 1 + i), 32'(b * 16 + i + 1)});
          for (int j = 0; j < C; j++) wq[j].push_back({32'(base + c + 1 + j), 32'(b * 16 + j + 5)});
          b++;
        end
      end
      #1;
      chk($sformatf("k%0d c%0d act_ready", k, c), bus.act_ready_o, feed && bus.wgt_valid_i);
      chk($sformatf("k%0d c%0d wgt_ready", k, c), bus.wgt_ready_o, feed && bus.act_valid_i);
      chk($sformatf("k%0d c%0d done", k, c), bus.done_o, c == done_c);
      chk($sformatf("k%0d c%0d busy", k, c), bus.busy_o, c <= done_c);
      if (stall > 0 && c == stall + 1) chk("stall bubble row0", bus.input_valid_o[0], 0);
    end
    for (int i = 0; i < R; i++) chk($sformatf("k%0d row%0d drained", k, i), rq[i].size(), 0);
    for (int j = 0; j < C; j++) chk($sformatf("k%0d col%0d drained", k, j), wq[j].size(), 0);
  endtask
  initial begin
    vec[0] = '{k: 1, stall: -1, done_c: 10, poke: 0};
    vec[1] = '{k: 3, stall: -1, done_c: 12, poke: 0};
    vec[2] = '{k: 3, stall: 2, done_c: 13, poke: 0};
    vec[3] = '{k: 0, stall: -1, done_c: 1, poke: 0};
    vec[4] = '{k: 5, stall: -1, done_c: 14, poke: 1};
    bus.start_i = 1'b0;
    bus.k_len_i = '0;
    bus.act_data_i = '0;
    bus.act_valid_i = 1'b0;
    bus.wgt_data_i = '0;
    bus.wgt_valid_i = 1'b0;
    repeat (3) step();
    chk_idle_outputs("reset");
    rst = 1'b0;
    step();
    for (int n = 0; n < 5; n++) run_pass(vec[n].k, vec[n].stall, vec[n].done_c, vec[n].poke);
    bus.start_i = 1'b1;
    bus.k_len_i = 11'd4;
    for (int c = 1; c <= 3; c++) begin
      step();
      bus.start_i = 1'b0;
      bus.act_valid_i = c < 3;
      bus.wgt_valid_i = c < 3;
      for (int i = 0; i < R; i++) bus.act_data_i[i] = 32'(200 + c * 16 + i);
      for (int j = 0; j < C; j++) bus.wgt_data_i[j] = 32'(300 + c * 16 + j);
      if (c < 3) begin
        for (int i = 0; i < R; i++) rq[i].push_back({32'(tick + 1 + i), 32'(200 + c * 16 + i)});
        for (int j = 0; j < C; j++) wq[j].push_back({32'(tick + 1 + j), 32'(300 + c * 16 + j)});
      end
      rst = c == 3;
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < R; i++) rq[i].delete();
    for (int j = 0; j < C; j++) wq[j].delete();
    chk_idle_outputs("midreset");
    for (int c = 0; c < 20; c++) begin
      step();
      chk("midreset no done", bus.done_o, 0);
      chk("midreset idle", bus.busy_o, 0);
    end
    run_pass(2, -1, 11, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
